branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
In-order branch tracking queue that drives the branch-update interface of the correlating branch predictor.
- Dispatch allocates one entry per branch, in program order. Each entry records the PC, the predicted next PC and the global-history snapshot.
- The branch ALU resolves entries out of order by tag.
- Resolved entries retire in order from the head. Each retirement emits one predictor update.
- A mispredict additionally raises a one-cycle front-end flush/redirect and discards every younger entry.

Parameters:
NUM_ENTRY, 8, queue depth (power of two, >=2)
BW_ADDRESS, 32, PC width
NUM_GLOBAL_HISTORY, 4, global-history snapshot width
BW_TAG, $clog2(NUM_ENTRY), entry tag width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_alloc_valid  input  1  dispatch requests an entry
o_alloc_ready  output  1  entry available this cycle
o_alloc_tag  output  BW_TAG  tag assigned on accepted alloc (= tail index)
i_alloc_pc  input  BW_ADDRESS  branch PC
i_alloc_predicted_pc_next  input  BW_ADDRESS  predicted next PC
i_alloc_global_history  input  NUM_GLOBAL_HISTORY  history used for the prediction
i_resolve_valid  input  1  branch ALU result valid
i_resolve_tag  input  BW_TAG  entry being resolved
i_resolve_taken  input  1  actual direction
i_resolve_target  input  BW_ADDRESS  actual taken target
o_branch_valid  output  1  predictor update strobe (single cycle)
o_branch_pc  output  BW_ADDRESS  retired branch PC
o_branch_correct_pc_next  output  BW_ADDRESS  actual next PC
o_branch_global_history  output  NUM_GLOBAL_HISTORY  stored snapshot
o_branch_correct_prediction  output  1  predicted == actual next PC
o_flush  output  1  mispredict flush pulse
o_redirect_pc  output  BW_ADDRESS  fetch redirect target

Behaviour:
Reset and pointers:
- Reset is asynchronous, active-low.
- Reset state: head=tail=0, count=0, all entries FREE.
- All outputs reset to 0 except o_alloc_ready=1.
- Reset mid-operation drops all entries; no update is emitted for them.

Entry states:
- FREE -> WAIT on accepted alloc.
- WAIT -> DONE on resolve.
- DONE -> FREE on retire or flush.

Alloc:
- Accepted when i_alloc_valid && o_alloc_ready.
- o_alloc_ready = (count != NUM_ENTRY) && !retire_mispredict.
- When full, ready stays low even if a retire happens the same cycle.
- Tail wraps modulo NUM_ENTRY.

Resolve:
- correct_pc_next = i_resolve_taken ? i_resolve_target : pc+4 (BW_ADDRESS wrap).
- The result is latched into the entry and the entry becomes DONE at the next edge.
- A resolve whose tag is FREE (flushed) or already DONE is ignored.

Retire:
- Evaluated each cycle on the head entry. If head is DONE: pop head, count-1.
- All o_branch_* outputs are registered; o_branch_valid pulses the cycle after retire.
- Latency: resolve of the head at cycle N -> o_branch_valid at N+2.
- Throughput: at most one retire per cycle.
- Simultaneous alloc and correct retire: both take effect; count unchanged.

Mispredict:
- Condition: retiring entry has predicted_pc_next != correct_pc_next.
- In the same registered cycle as o_branch_valid:
  - o_flush=1 and o_redirect_pc=correct_pc_next.
  - o_branch_correct_prediction=0.
- All entries are freed; head=tail=old head+1; count=0.
- Allocation is blocked in the retire cycle.
- A resolve arriving in the retire cycle is dropped.
- o_flush and o_branch_valid are low in every cycle with no retire.

Optional Feature:
Macro BRANCH_RESOLVE_STATS_EN.
- Defined: adds outputs o_stat_retired[31:0] and o_stat_mispredict[31:0].
  - Saturating counters, reset to 0.
  - o_stat_retired increments on each retire; o_stat_mispredict on each mispredict retire.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle -> o_alloc_ready=1, o_branch_valid=0, o_flush=0, o_alloc_tag=0.
- Alloc pc=0x100, pred=0x104, hist=4'b1010; resolve taken=0 -> one update: pc=0x100, correct_pc_next=0x104, hist=4'b1010, correct_prediction=1, no flush, valid exactly 2 cycles after resolve.
- Alloc tags 0,1,2 (pc 0x10/0x20/0x30, pred pc+4); resolve tag 2, then 1, then 0 -> updates emitted in order 0x10, 0x20, 0x30 on consecutive cycles.
- Alloc tags 0..3; tag0 pred=0x44, resolve taken target=0x200 ->
  - update correct_prediction=0; o_flush=1, o_redirect_pc=0x200.
  - count=0, next o_alloc_tag=1.
  - A later resolve of tag 2 produces no update.
- Alloc 8 branches unresolved -> o_alloc_ready=0 and a 9th alloc is ignored; resolve head -> ready returns 1 the cycle after the retire.
- Assert rst_n with 3 entries DONE -> no update emitted; all outputs at reset values.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Branch resolve unit bus: dispatch alloc, branch ALU resolve, predictor update and flush.
// The stats outputs exist only when BRANCH_RESOLVE_STATS_EN is defined.
interface branch_resolve_unit_if #(
   parameter int NUM_ENTRY          = 8,
   parameter int BW_ADDRESS         = 32,
   parameter int NUM_GLOBAL_HISTORY = 4,
   parameter int BW_TAG             = $clog2(NUM_ENTRY)
);
   logic                          i_alloc_valid;
   logic                          o_alloc_ready;
   logic [BW_TAG-1:0]             o_alloc_tag;
   logic [BW_ADDRESS-1:0]         i_alloc_pc;
   logic [BW_ADDRESS-1:0]         i_alloc_predicted_pc_next;
   logic [NUM_GLOBAL_HISTORY-1:0] i_alloc_global_history;
   logic                          i_resolve_valid;
   logic [BW_TAG-1:0]             i_resolve_tag;
   logic                          i_resolve_taken;
   logic [BW_ADDRESS-1:0]         i_resolve_target;
   logic                          o_branch_valid;
   logic [BW_ADDRESS-1:0]         o_branch_pc;
   logic [BW_ADDRESS-1:0]         o_branch_correct_pc_next;
   logic [NUM_GLOBAL_HISTORY-1:0] o_branch_global_history;
   logic                          o_branch_correct_prediction;
   logic                          o_flush;
   logic [BW_ADDRESS-1:0]         o_redirect_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0]                   o_stat_retired;
   logic [31:0]                   o_stat_mispredict;
`endif

   modport master (
      output i_alloc_valid, i_alloc_pc, i_alloc_predicted_pc_next, i_alloc_global_history,
             i_resolve_valid, i_resolve_tag, i_resolve_taken, i_resolve_target,
      input  o_alloc_ready, o_alloc_tag, o_branch_valid, o_branch_pc, o_branch_correct_pc_next,
             o_branch_global_history, o_branch_correct_prediction, o_flush, o_redirect_pc
`ifdef BRANCH_RESOLVE_STATS_EN
      , input o_stat_retired, o_stat_mispredict
`endif
   );

   modport slave (
      input  i_alloc_valid, i_alloc_pc, i_alloc_predicted_pc_next, i_alloc_global_history,
             i_resolve_valid, i_resolve_tag, i_resolve_taken, i_resolve_target,
      output o_alloc_ready, o_alloc_tag, o_branch_valid, o_branch_pc, o_branch_correct_pc_next,
             o_branch_global_history, o_branch_correct_prediction, o_flush, o_redirect_pc
`ifdef BRANCH_RESOLVE_STATS_EN
      , output o_stat_retired, o_stat_mispredict
`endif
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order branch tracking queue: out-of-order resolve, in-order retire into predictor updates.
// Optional retire/mispredict counters are enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
   parameter int NUM_ENTRY          = 8,
   parameter int BW_ADDRESS         = 32,
   parameter int NUM_GLOBAL_HISTORY = 4,
   parameter int BW_TAG             = $clog2(NUM_ENTRY)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   branch_resolve_unit_if.slave bus
);
   typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_DONE} entry_state_t;
   localparam int BW_COUNT = BW_TAG + 1;

   entry_state_t                  state_reg   [NUM_ENTRY];
   entry_state_t                  state_next  [NUM_ENTRY];
   logic [BW_ADDRESS-1:0]         pc_mem      [NUM_ENTRY];
   logic [BW_ADDRESS-1:0]         pred_mem    [NUM_ENTRY];
   logic [BW_ADDRESS-1:0]         correct_mem [NUM_ENTRY];
   logic [NUM_GLOBAL_HISTORY-1:0] hist_mem    [NUM_ENTRY];

   logic [BW_TAG-1:0]   head_reg, head_next, tail_reg, tail_next;
   logic [BW_COUNT-1:0] count_reg, count_next;

   logic                  retire, retire_mispredict;
   logic                  alloc_ready, alloc_fire, resolve_fire;
   logic [BW_ADDRESS-1:0] resolve_pc_next;

   logic                          branch_valid_reg, correct_pred_reg, flush_reg;
   logic [BW_ADDRESS-1:0]         branch_pc_reg, correct_pc_reg, redirect_pc_reg;
   logic [NUM_GLOBAL_HISTORY-1:0] branch_hist_reg;

   assign retire            = (state_reg[head_reg] == ST_DONE);
   assign retire_mispredict = retire && (pred_mem[head_reg] != correct_mem[head_reg]);
   // A full queue stays closed even when the head retires this cycle.
   assign alloc_ready       = (count_reg != BW_COUNT'(NUM_ENTRY)) && !retire_mispredict;
   assign alloc_fire        = bus.i_alloc_valid && alloc_ready;
   assign resolve_fire      = bus.i_resolve_valid && !retire_mispredict &&
                              (state_reg[bus.i_resolve_tag] == ST_WAIT);
   assign resolve_pc_next   = bus.i_resolve_taken ? bus.i_resolve_target
                                                  : pc_mem[bus.i_resolve_tag] + BW_ADDRESS'(4);

   always_comb begin
      for (int i = 0; i < NUM_ENTRY; i++) state_next[i] = state_reg[i];
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (retire_mispredict) begin
         for (int i = 0; i < NUM_ENTRY; i++) state_next[i] = ST_FREE;
         head_next  = head_reg + 1'b1;
         tail_next  = head_reg + 1'b1;
         count_next = '0;
      end else begin
         if (alloc_fire) begin
            state_next[tail_reg] = ST_WAIT;
            tail_next            = tail_reg + 1'b1;
         end
         if (resolve_fire) state_next[bus.i_resolve_tag] = ST_DONE;
         if (retire) begin
            state_next[head_reg] = ST_FREE;
            head_next            = head_reg + 1'b1;
         end
         count_next = count_reg + BW_COUNT'(alloc_fire) - BW_COUNT'(retire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRY; i++) state_reg[i] <= ST_FREE;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Payload storage needs no reset; entry state gates every read.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         pc_mem[tail_reg]   <= bus.i_alloc_pc;
         pred_mem[tail_reg] <= bus.i_alloc_predicted_pc_next;
         hist_mem[tail_reg] <= bus.i_alloc_global_history;
      end
      if (resolve_fire) correct_mem[bus.i_resolve_tag] <= resolve_pc_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_valid_reg <= 1'b0;
         flush_reg        <= 1'b0;
         correct_pred_reg <= 1'b0;
         branch_pc_reg    <= '0;
         correct_pc_reg   <= '0;
         redirect_pc_reg  <= '0;
         branch_hist_reg  <= '0;
      end else begin
         branch_valid_reg <= retire;
         flush_reg        <= retire_mispredict;
         if (retire) begin
            branch_pc_reg    <= pc_mem[head_reg];
            correct_pc_reg   <= correct_mem[head_reg];
            branch_hist_reg  <= hist_mem[head_reg];
            correct_pred_reg <= !retire_mispredict;
         end
         if (retire_mispredict) redirect_pc_reg <= correct_mem[head_reg];
      end
   end

   assign bus.o_alloc_ready               = alloc_ready;
   assign bus.o_alloc_tag                 = tail_reg;
   assign bus.o_branch_valid              = branch_valid_reg;
   assign bus.o_branch_pc                 = branch_pc_reg;
   assign bus.o_branch_correct_pc_next    = correct_pc_reg;
   assign bus.o_branch_global_history     = branch_hist_reg;
   assign bus.o_branch_correct_prediction = correct_pred_reg;
   assign bus.o_flush                     = flush_reg;
   assign bus.o_redirect_pc               = redirect_pc_reg;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_retired_reg, stat_mispredict_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_retired_reg    <= '0;
         stat_mispredict_reg <= '0;
      end else begin
         if (retire && (stat_retired_reg != '1))
            stat_retired_reg <= stat_retired_reg + 32'd1;
         if (retire_mispredict && (stat_mispredict_reg != '1))
            stat_mispredict_reg <= stat_mispredict_reg + 32'd1;
      end
   end

   assign bus.o_stat_retired    = stat_retired_reg;
   assign bus.o_stat_mispredict = stat_mispredict_reg;
`endif
endmodule
